// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared constants for the iterative multiply/divide unit. The controller and
// hazard unit use the same header.
//   md_op_t    : encoding of the 2-bit op port (mult, multu, div, divu)
//   md_state_t : FSM state encoding (IDLE, RUN, FIX)
//   md_mode_t  : datapath mode seen by each iteration step
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } md_state_t;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } md_mode_t;

   function automatic logic op_is_div(input md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic op_is_signed(input md_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational radix-2 iteration on the pair {acc, mq}.
//   mode     : MODE_MUL -> shift-add (right shift, mq holds multiplier)
//              MODE_DIV -> restoring shift-subtract (left shift, mq holds
//                          dividend bits, becomes the quotient)
//   operand  : multiplicand (mul) or divisor (div), unsigned magnitude
//   acc_in   : running upper half / partial remainder
//   mq_in    : multiplier / dividend-quotient register
//   acc_out, mq_out : values after this step
// -----------------------------------------------------------------------------
module muldiv_step
   import muldiv_unit_pkg::*;
#(
   parameter int BIT_WIDTH = 32
) (
   input  md_mode_t             mode,
   input  logic [BIT_WIDTH-1:0] operand,
   input  logic [BIT_WIDTH-1:0] acc_in,
   input  logic [BIT_WIDTH-1:0] mq_in,
   output logic [BIT_WIDTH-1:0] acc_out,
   output logic [BIT_WIDTH-1:0] mq_out
);

   logic [BIT_WIDTH:0] sum;
   logic [BIT_WIDTH:0] rem_shift;
   logic [BIT_WIDTH:0] diff;

   // Remainder is always below the divisor, so the shifted remainder fits in
   // BIT_WIDTH+1 bits and diff[BIT_WIDTH] is a clean borrow flag.
   assign sum       = {1'b0, acc_in} + {1'b0, operand};
   assign rem_shift = {acc_in, mq_in[BIT_WIDTH-1]};
   assign diff      = rem_shift - {1'b0, operand};

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      acc_out = acc_in;
      mq_out  = mq_in;
      if (mode == MODE_DIV) begin
         acc_out = diff[BIT_WIDTH] ? rem_shift[BIT_WIDTH-1:0] : diff[BIT_WIDTH-1:0];
         mq_out  = {mq_in[BIT_WIDTH-2:0], ~diff[BIT_WIDTH]};
      end else if (mq_in[0]) begin
         acc_out = sum[BIT_WIDTH:1];
         mq_out  = {sum[0], mq_in[BIT_WIDTH-1:1]};
      end else begin
         acc_out = {1'b0, acc_in[BIT_WIDTH-1:1]};
         mq_out  = {acc_in[0], mq_in[BIT_WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes; signs are reapplied in the FIX state.
// Ports:
//   clk, rst          : clock (rising edge), async active-high reset
//   start, op         : launch mult/multu/div/divu, sampled only in IDLE
//   srcA, srcB        : rs / rt operands, captured at start
//   hiWrite, loWrite  : mthi / mtlo, honoured only in IDLE without start
//   wrData            : mthi / mtlo data
//   hi, lo            : HI / LO registers
//   busy              : operation in flight (stall IF/ID and mfhi/mflo)
//   done              : one-cycle completion pulse
//   divByZero         : divide by zero flag, valid with done
// Latency: BIT_WIDTH/BITS_PER_CYCLE + 1 cycles from the start edge to done.
// BIT_WIDTH must be even and a multiple of BITS_PER_CYCLE.
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int BIT_WIDTH      = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [BIT_WIDTH-1:0] srcA,
   input  logic [BIT_WIDTH-1:0] srcB,
   input  logic                 hiWrite,
   input  logic                 loWrite,
   input  logic [BIT_WIDTH-1:0] wrData,
   output logic [BIT_WIDTH-1:0] hi,
   output logic [BIT_WIDTH-1:0] lo,
   output logic                 busy,
   output logic                 done,
   output logic                 divByZero
);

   localparam int              N        = BIT_WIDTH / BITS_PER_CYCLE;
   localparam int              CNT_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   md_state_t            state, next_state;
   md_mode_t             mode_q;
   logic [BIT_WIDTH-1:0] operand_q;
   logic [BIT_WIDTH-1:0] acc_q;
   logic [BIT_WIDTH-1:0] mq_q;
   logic                 neg_main_q;   // negate product / quotient
   logic                 neg_rem_q;    // negate remainder (dividend sign)
   logic                 div0_q;
   logic [CNT_W-1:0]     cnt_q;

   // ---------------------------------------------------------------- start decode
   md_op_t               op_in;
   logic                 op_div;
   logic                 a_neg, b_neg;
   logic [BIT_WIDTH-1:0] a_mag, b_mag;

   assign op_in  = md_op_t'(op);
   assign op_div = op_is_div(op_in);
   assign a_neg  = op_is_signed(op_in) & srcA[BIT_WIDTH-1];
   assign b_neg  = op_is_signed(op_in) & srcB[BIT_WIDTH-1];
   // The most-negative value negates to itself, which is its correct
   // unsigned magnitude.
   assign a_mag  = a_neg ? -srcA : srcA;
   assign b_mag  = b_neg ? -srcB : srcB;

   // ---------------------------------------------------------------- step chain
   logic [BIT_WIDTH-1:0] acc_next, mq_next;

   for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_stage
      logic [BIT_WIDTH-1:0] acc_i, mq_i, acc_o, mq_o;
      if (g == 0) begin : g_first
         assign acc_i = acc_q;
         assign mq_i  = mq_q;
      end else begin : g_chain
         assign acc_i = g_stage[g-1].acc_o;
         assign mq_i  = g_stage[g-1].mq_o;
      end
      muldiv_step #(.BIT_WIDTH(BIT_WIDTH)) u_step (
         .mode    (mode_q),
         .operand (operand_q),
         .acc_in  (acc_i),
         .mq_in   (mq_i),
         .acc_out (acc_o),
         .mq_out  (mq_o)
      );
   end

   assign acc_next = g_stage[BITS_PER_CYCLE-1].acc_o;
   assign mq_next  = g_stage[BITS_PER_CYCLE-1].mq_o;

   // ---------------------------------------------------------------- sign fix-up
   logic [2*BIT_WIDTH-1:0] prod, prod_fix;
   logic [BIT_WIDTH-1:0]   quot_fix, rem_fix, hi_res, lo_res;

   assign prod     = {acc_q, mq_q};
   assign prod_fix = neg_main_q ? -prod : prod;
   // Divide by zero: quotient forced to all ones; the remainder path already
   // yields |dividend| and restoring the dividend sign returns raw srcA.
   assign quot_fix = div0_q ? '1 : (neg_main_q ? -mq_q : mq_q);
   assign rem_fix  = neg_rem_q ? -acc_q : acc_q;
   assign hi_res   = (mode_q == MODE_DIV) ? rem_fix  : prod_fix[2*BIT_WIDTH-1:BIT_WIDTH];
   assign lo_res   = (mode_q == MODE_DIV) ? quot_fix : prod_fix[BIT_WIDTH-1:0];

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (start) next_state = ST_RUN;
         ST_RUN:  if (cnt_q == CNT_LAST) next_state = ST_FIX;
         ST_FIX:  next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != ST_IDLE);
   end

   // ---------------------------------------------------------------- datapath
   // NOTE: the whole datapath is reset, not just control, because an abort
   // mid-RUN must leave HI/LO, flags and counter cleared immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= MODE_MUL;
         operand_q  <= '0;
         acc_q      <= '0;
         mq_q       <= '0;
         neg_main_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         div0_q     <= 1'b0;
         cnt_q      <= '0;
         hi         <= '0;
         lo         <= '0;
         done       <= 1'b0;
         divByZero  <= 1'b0;
      end else begin
         done      <= (state == ST_FIX);
         divByZero <= (state == ST_FIX) && div0_q;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mode_q     <= op_div ? MODE_DIV : MODE_MUL;
                  operand_q  <= op_div ? b_mag : a_mag;
                  mq_q       <= op_div ? a_mag : b_mag;
                  acc_q      <= '0;
                  neg_main_q <= a_neg ^ b_neg;
                  neg_rem_q  <= a_neg;
                  div0_q     <= op_div && (srcB == '0);
                  cnt_q      <= '0;
               end else begin
                  // start wins over a simultaneous mthi/mtlo
                  if (hiWrite) hi <= wrData;
                  if (loWrite) lo <= wrData;
               end
            end
            ST_RUN: begin
               acc_q <= acc_next;
               mq_q  <= mq_next;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            ST_FIX: begin
               hi <= hi_res;
               lo <= lo_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, executing MIPS `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo`, `mfhi` and `mflo`. It sits beside the ALU in the EX stage of the next-generation pipelined datapath and completes each operation over several cycles. While it works, it drives `busy` so the hazard unit stalls IF/ID and any `mfhi`/`mflo` in EX. Width and throughput (bits retired per cycle) are parametrised.

## Interface
- `BIT_WIDTH`, 32: operand and HI/LO width; must be even.
- `BITS_PER_CYCLE`, 1: iteration steps per clock; must divide `BIT_WIDTH`. N = `BIT_WIDTH`/`BITS_PER_CYCLE`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch the operation in `op`; sampled only in IDLE.
- `op`  in  2  00 `mult`, 01 `multu`, 10 `div`, 11 `divu`.
- `srcA`  in  BIT_WIDTH  rs value (multiplicand / dividend).
- `srcB`  in  BIT_WIDTH  rt value (multiplier / divisor).
- `hiWrite`  in  1  `mthi`: HI <= `wrData`.
- `loWrite`  in  1  `mtlo`: LO <= `wrData`.
- `wrData`  in  BIT_WIDTH  `mthi`/`mtlo` data.
- `hi`  out  BIT_WIDTH  HI register; reset 0.
- `lo`  out  BIT_WIDTH  LO register; reset 0.
- `busy`  out  1  operation in flight; reset 0.
- `done`  out  1  one-cycle completion pulse; reset 0.
- `divByZero`  out  1  valid with `done`; set for `div`/`divu` with `srcB`=0; reset 0.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE + `start`:
  - latch `op`; take operand magnitudes (signed ops only); record result signs; clear accumulator; step counter <= 0; go to RUN.
- RUN:
  - each cycle, apply `BITS_PER_CYCLE` chained steps.
  - multiply step: shift-add on {acc, multiplier}.
  - divide step: restoring shift-subtract on {rem, quotient}.
  - counter increments; at N-1 go to FIX.
- FIX:
  - apply sign correction (two's complement negate where required), write HI/LO, pulse `done`, return to IDLE.
- Multiply results:
  - HI = upper half, LO = lower half of the 2·BIT_WIDTH product.
- Divide results:
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
- Divide by zero:
  - LO = all ones, HI = dividend (raw `srcA`), `divByZero` = 1.
  - Runs the full latency; no early exit.
- Signed overflow (most-negative / −1):
  - LO = most-negative, HI = 0; `divByZero` = 0.
- `hiWrite`/`loWrite`:
  - take effect at the next edge, only in IDLE; ignored while `busy`.
  - If `start` and a write arrive together in IDLE, `start` wins and the write is dropped.
- `start` while `busy` is ignored.
- Operands are captured at start; later changes to `srcA`/`srcB` have no effect.
- `rst` at any time (including mid-RUN): immediately return to IDLE and clear HI, LO, `busy`, `done`, `divByZero` and the counter.

## Timing
- `start` sampled at edge k:
  - `busy` = 1 after edge k, through the cycle ending at edge k+N+1.
  - HI/LO updated at edge k+N+1.
  - `done` = 1 for exactly the cycle after edge k+N+1, which is also the cycle in which `busy` = 0.
- Total latency: N+1 cycles (33 at defaults).
- Back-to-back: a new `start` is accepted in the `done` cycle.
- `hi`/`lo` are registered outputs; they hold their old values until the completing edge, so reading them while `busy` returns stale data. The hazard unit must stall on `busy`.
- `divByZero` is registered and valid only while `done` = 1.
- No combinational path from any input to any output.

## Structure
- Shared constants header: `op` encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`) and FSM state encodings. The controller and hazard unit include the same header.
- Sub-module `muldiv_step`: combinational single radix-2 step with a mode input (mul/div). Instantiate `BITS_PER_CYCLE` times in a generate chain.
- Top level: FSM, counter, sign handling, HI/LO registers.

## Test plan
- `mult` −3 × 7 (defaults) -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high 33 cycles; `done` pulse one cycle.
- `multu` 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001; then `div` −7 ÷ 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- `divu` 7 ÷ 0 -> `lo`=0xFFFFFFFF, `hi`=0x00000007, `divByZero`=1 with `done`; `div` 0x80000000 ÷ 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0, `divByZero`=0.
- Second `start` and `loWrite` (`wrData`=0x1234) issued mid-RUN -> both ignored, first result intact. `mtlo` 0x1234 in IDLE -> `lo`=0x1234 next cycle.
- `rst` pulsed at cycle 10 of a `mult` -> `busy`, `done`, `hi`, `lo` all 0 immediately. Next `start` completes normally after 33 cycles.
- `BITS_PER_CYCLE`=4: `divu` 100 ÷ 7 -> `lo`=14, `hi`=2, `done` 9 cycles after start.
